// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined two-level carry-lookahead adder/subtractor with a
// valid/ready handshake on both sides and full back-pressure.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational from out_ready)
//   a, b, cin, sub        operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready result handshake
//   sum, cout, overflow   result, carry out of MSB (sub: 1 = no borrow), signed overflow
//   zero                  sum == 0
//   grp_g, grp_p          whole-word generate/propagate of the accepted operands
//
// Parameters: WIDTH (multiple of BLOCK, >= 4), BLOCK (bits per lookahead group),
// STAGES (1..4, register stages from acceptance to result).
//
// Optional feature macro: SATURATE_EN -- when defined, an overflowing result
// saturates to the signed limit selected by the sign of a; otherwise it wraps.
module cla_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             grp_g,
  output logic             grp_p
);

  localparam int NGRP  = WIDTH / BLOCK;
  localparam int PKT_W = WIDTH + 5;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1 = '1;

  if (WIDTH < 4 || BLOCK < 1 || (WIDTH % BLOCK) != 0 || STAGES < 1 || STAGES > 4) begin : g_param_err
    $error("cla_adder_pipe: illegal parameters WIDTH=%0d BLOCK=%0d STAGES=%0d",
           WIDTH, BLOCK, STAGES);
  end

  // Mask of the k lowest bits; k == WIDTH wraps to all ones.
  function automatic logic [WIDTH-1:0] below(input int k);
    return (ONE << k) - ONE;
  endfunction

  // Flat sum-of-products lookahead: carry out of position n-1 given carry-in cb
  // into position 0. Each term is g[j] AND all p above j, so no rippled chain.
  function automatic logic la_carry(input int n, input logic [WIDTH-1:0] gv,
                                    input logic [WIDTH-1:0] pv, input logic cb);
    logic             c;
    logic [WIDTH-1:0] span;
    c = cb & ((pv | ~below(n)) == ALL1);
    for (int j = 0; j < n; j++) begin
      span = below(n) & ~below(j + 1);
      c = c | ((|(gv & (ONE << j))) & ((pv | ~span) == ALL1));
    end
    return c;
  endfunction

`ifdef SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] s, input logic ovf,
                                              input logic a_neg);
    if (!ovf) return s;
    return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic [WIDTH-1:0] y, g, p, c, s_raw, s_fin;
  logic             c0, ovf_w, zero_w, word_g, word_p;
  logic [NGRP-1:0]  blk_g, blk_p;
  logic [NGRP:0]    blk_c;
  logic [PKT_W-1:0] pkt_in;

  assign y  = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;
  assign g  = a & y;
  assign p  = a ^ y;

  // First level: group G/P per block; second level: carry into each block
  // from the group G/P vector; then per-bit carries inside each block.
  for (genvar k = 0; k < NGRP; k++) begin : g_blk
    assign blk_p[k] = &p[k*BLOCK +: BLOCK];
    assign blk_g[k] = la_carry(BLOCK, WIDTH'(g[k*BLOCK +: BLOCK]),
                               WIDTH'(p[k*BLOCK +: BLOCK]), 1'b0);
    assign blk_c[k] = la_carry(k, WIDTH'(blk_g), WIDTH'(blk_p), c0);
    for (genvar j = 0; j < BLOCK; j++) begin : g_bit
      assign c[k*BLOCK+j] = la_carry(j, WIDTH'(g[k*BLOCK +: BLOCK]),
                                     WIDTH'(p[k*BLOCK +: BLOCK]), blk_c[k]);
    end
  end
  assign blk_c[NGRP] = la_carry(NGRP, WIDTH'(blk_g), WIDTH'(blk_p), c0);
  assign word_g      = la_carry(NGRP, WIDTH'(blk_g), WIDTH'(blk_p), 1'b0);
  assign word_p      = &p;

  assign s_raw = p ^ c;
  assign ovf_w = (a[WIDTH-1] == y[WIDTH-1]) && (s_raw[WIDTH-1] != a[WIDTH-1]);
`ifdef SATURATE_EN
  assign s_fin = sat_fn(s_raw, ovf_w, a[WIDTH-1]);
`else
  assign s_fin = s_raw;
`endif
  assign zero_w = (s_fin == '0);
  assign pkt_in = {word_p, word_g, zero_w, ovf_w, blk_c[NGRP], s_fin};

  logic [STAGES-1:0] vld_vec;
  logic [PKT_W-1:0]  pkt_vec [STAGES];

  // A stage loads when it or any stage downstream of it is empty, or when the
  // consumer takes the result: this is the collapsed form of "empty or moving".
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             vld_d, vld_q, src_vld, ld;
    logic [PKT_W-1:0] pkt_d, pkt_q, src_pkt;

    // ---- stage boundary i ----
    if (i == 0) begin : g_src_in
      assign src_vld = in_valid;
      assign src_pkt = pkt_in;
    end else begin : g_src_prev
      assign src_vld = vld_vec[i-1];
      assign src_pkt = pkt_vec[i-1];
    end

    assign ld = out_ready || !(&vld_vec[STAGES-1:i]);

    // Data only changes when a real item arrives, so bubbles leave the last
    // result fields visible.
    always_comb begin
      vld_d = vld_q;
      pkt_d = pkt_q;
      if (ld) begin
        vld_d = src_vld;
        if (src_vld) pkt_d = src_pkt;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= 1'b0;
        pkt_q <= '0;
      end else begin
        vld_q <= vld_d;
        pkt_q <= pkt_d;
      end
    end

    assign vld_vec[i] = vld_q;
    assign pkt_vec[i] = pkt_q;
  end

  assign in_ready  = out_ready || !(&vld_vec);
  assign out_valid = vld_vec[STAGES-1];
  assign {grp_p, grp_g, zero, overflow, cout, sum} = pkt_vec[STAGES-1];

endmodule
